// File: rtl/fastica_pkg.sv
// fastica_pkg: shared widths, fixed-point constants, error-check states and clog2 helper
package fastica_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  localparam logic signed [15:0] ONE_Q14 = 16'sh4000;
  localparam logic [31:0] ONE_Q28 = 32'h1000_0000;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_FINAL} err_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fastica_err_mac.sv
// fastica_err_mac: registered product stage, row accumulator and ||dot|-1| error
module fastica_err_mac
  import fastica_pkg::*;
#(
  parameter int N = 4,
  parameter int DATA_W = fastica_pkg::DATA_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    vld,
  input  logic                                    clr,
  input  logic                                    last,
  input  logic signed [DATA_W-1:0]                a,
  input  logic signed [DATA_W-1:0]                b,
  output logic                                    e_vld,
  output logic [2*DATA_W+clog2(N)-1:0]            e
);
  localparam int PW = 2 * DATA_W;
  localparam int ACC_W = PW + clog2(N);
  logic signed [PW-1:0] prod_q;
  logic vld_q, clr_q, last_q;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [ACC_W-1:0] acc_abs;
  logic signed [ACC_W:0] diff;
  assign acc_sum = (clr_q ? '0 : acc) + ACC_W'(prod_q);
  assign acc_abs = acc_sum[ACC_W-1] ? -acc_sum : acc_sum;
  assign diff = $signed({1'b0, acc_abs}) - $signed((ACC_W+1)'(ONE_Q28));
  assign e = ACC_W'(diff[ACC_W] ? -diff : diff);
  assign e_vld = vld_q && last_q;
  // product register, then accumulate the row sum one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q <= 1'b0;
      clr_q <= 1'b0;
      last_q <= 1'b0;
      acc <= '0;
    end else begin
      prod_q <= PW'(a) * PW'(b);
      vld_q <= vld;
      clr_q <= clr;
      last_q <= last;
      if (vld_q) acc <= acc_sum;
    end
  end
endmodule

// File: rtl/fastica_error_calc.sv
// fastica_error_calc: per-row |w_new.w_old| convergence check with iteration cap
module fastica_error_calc
  import fastica_pkg::*;
#(
  parameter int N = 4,
  parameter int DATA_W = fastica_pkg::DATA_W,
  parameter logic [15:0] TOL = 16'd16,
  parameter logic [7:0] MAX_ITER = 8'd200
) (
  input  logic                        clk_error,
  input  logic                        go_fastica,
  input  logic                        en_error,
  output logic                        rd_en,
  output logic [2*clog2(N)-1:0]       rd_addr,
  input  logic signed [DATA_W-1:0]    w_new_rdata,
  input  logic signed [DATA_W-1:0]    w_old_rdata,
  output logic                        error_busy,
  output logic                        isConverge,
  output logic                        timeout,
  output logic [DATA_W+1:0]           max_err,
  output logic [7:0]                  iter_cnt
);
  localparam int AW = clog2(N);
  localparam int ACC_W = 2 * DATA_W + AW;
  localparam logic [ACC_W-1:0] TOL_Q28 = ACC_W'(TOL) << FRAC_W;
  err_state_t state, nstate;
  logic en_prev, start, last_addr, rd_q, e_vld, fail_run, fail_nxt;
  logic [AW-1:0] row, col, col_q;
  logic [ACC_W-1:0] e_row;
  logic [DATA_W+1:0] e_sat, max_run, max_nxt;
  logic [7:0] iter_nxt;
  assign start = en_error && !en_prev && state == ST_IDLE;
  assign last_addr = row == AW'(N-1) && col == AW'(N-1);
  assign rd_en = state == ST_READ;
  assign rd_addr = rd_en ? {row, col} : '0;
  assign error_busy = state != ST_IDLE;
  assign iter_nxt = iter_cnt == 8'hFF ? iter_cnt : iter_cnt + 8'd1;
  assign e_sat = |e_row[ACC_W-1:FRAC_W+DATA_W+2] ? '1 : e_row[FRAC_W+DATA_W+1:FRAC_W];
  assign max_nxt = e_vld && e_sat > max_run ? e_sat : max_run;
  assign fail_nxt = fail_run || (e_vld && e_row >= TOL_Q28);
  fastica_err_mac #(.N(N), .DATA_W(DATA_W)) u_mac (
    .clk(clk_error),
    .rst_n(go_fastica),
    .vld(rd_q),
    .clr(col_q == '0),
    .last(col_q == AW'(N-1)),
    .a(w_new_rdata),
    .b(w_old_rdata),
    .e_vld(e_vld),
    .e(e_row)
  );
  // state register and start-edge detector
  always_ff @(posedge clk_error or negedge go_fastica) begin
    if (!go_fastica) begin
      state <= ST_IDLE;
      en_prev <= 1'b0;
    end else begin
      state <= nstate;
      en_prev <= en_error;
    end
  end
  // next-state: read N*N elements, drain the pipeline, then commit results
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  nstate = start ? ST_READ : ST_IDLE;
      ST_READ:  nstate = last_addr ? ST_DRAIN : ST_READ;
      ST_DRAIN: nstate = ST_FINAL;
      default:  nstate = ST_IDLE;
    endcase
  end
  // row-major address walk; the delayed copy tags data returning next cycle
  always_ff @(posedge clk_error or negedge go_fastica) begin
    if (!go_fastica) begin
      row <= '0;
      col <= '0;
      rd_q <= 1'b0;
      col_q <= '0;
    end else begin
      rd_q <= rd_en;
      col_q <= col;
      if (start) begin
        row <= '0;
        col <= '0;
      end else if (rd_en) begin
        col <= col == AW'(N-1) ? '0 : col + 1'b1;
        if (col == AW'(N-1)) row <= last_addr ? '0 : row + 1'b1;
      end
    end
  end
  // running fail flag and worst row error for the check in flight
  always_ff @(posedge clk_error or negedge go_fastica) begin
    if (!go_fastica) begin
      fail_run <= 1'b0;
      max_run <= '0;
    end else if (start) begin
      fail_run <= 1'b0;
      max_run <= '0;
    end else begin
      fail_run <= fail_nxt;
      max_run <= max_nxt;
    end
  end
  // commit verdict; the last row's error arrives in FINAL so use the merged values
  always_ff @(posedge clk_error or negedge go_fastica) begin
    if (!go_fastica) begin
      isConverge <= 1'b0;
      timeout <= 1'b0;
      max_err <= '0;
      iter_cnt <= '0;
    end else if (start) begin
      isConverge <= 1'b0;
      timeout <= 1'b0;
    end else if (state == ST_FINAL) begin
      iter_cnt <= iter_nxt;
      max_err <= max_nxt;
      isConverge <= !fail_nxt || iter_nxt >= MAX_ITER;
      timeout <= fail_nxt && iter_nxt >= MAX_ITER;
    end
  end
endmodule

// File: tb/tb_fastica_error_calc.sv
// tb_fastica_error_calc: directed and random convergence checks against a dot-product model
module tb_fastica_error_calc;
  localparam logic [15:0] TOL = 16'd16;
  localparam int MAXI = 3;
  logic clk = 1'b0;
  logic go = 1'b0;
  logic en = 1'b0;
  logic rd_en, busy, conv, tmo;
  logic [3:0] rd_addr;
  logic signed [15:0] wn_d, wo_d;
  logic [17:0] max_err;
  logic [7:0] iter;
  logic signed [15:0] wn [16];
  logic signed [15:0] wo [16];
  int checks = 0;
  int passes = 0;
  int m_iter = 0;

  fastica_error_calc #(.N(4), .DATA_W(16), .TOL(TOL), .MAX_ITER(8'(MAXI))) dut (
    .clk_error(clk),
    .go_fastica(go),
    .en_error(en),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .w_new_rdata(wn_d),
    .w_old_rdata(wo_d),
    .error_busy(busy),
    .isConverge(conv),
    .timeout(tmo),
    .max_err(max_err),
    .iter_cnt(iter)
  );

  always #5 clk = ~clk;

  // W storage: one-cycle read latency
  always @(posedge clk) begin
    wn_d <= wn[rd_addr];
    wo_d <= wo[rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic set_ident(input int sn);
    for (int i = 0; i < 16; i++) begin
      wo[i] = (i % 5 == 0) ? 16'sh4000 : 16'sh0;
      wn[i] = (i % 5 == 0) ? 16'(sn * 16384) : 16'sh0;
    end
  endtask

  // e_r = ||dot_r| - 1| in Q4.28; pass when every e_r < TOL*2^14
  task automatic ref_model(output bit pass, output longint mx);
    longint dot, e, s;
    pass = 1'b1;
    mx = 0;
    for (int r = 0; r < 4; r++) begin
      dot = 0;
      for (int c = 0; c < 4; c++) dot += longint'(wn[r*4+c]) * longint'(wo[r*4+c]);
      e = dot < 0 ? -dot : dot;
      e = e - 268435456;
      e = e < 0 ? -e : e;
      if (e >= longint'(TOL) * 16384) pass = 1'b0;
      s = e / 16384;
      if (s > 262143) s = 262143;
      if (s > mx) mx = s;
    end
  endtask

  task automatic run_check(input string tag);
    bit pass, cs;
    longint mx;
    int bc, rc;
    ref_model(pass, mx);
    m_iter = m_iter == 255 ? 255 : m_iter + 1;
    bc = 0;
    rc = 0;
    cs = 1'b0;
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    while (busy && bc < 100) begin
      bc++;
      rc += int'(rd_en);
      cs |= conv;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(bc), 64'd18);
    chk({tag, " rd_pulses"}, 64'(rc), 64'd16);
    chk({tag, " conv_while_busy"}, 64'(cs), 64'd0);
    chk({tag, " isConverge"}, 64'(conv), 64'(pass || m_iter >= MAXI));
    chk({tag, " timeout"}, 64'(tmo), 64'(!pass && m_iter >= MAXI));
    chk({tag, " max_err"}, 64'(max_err), 64'(mx));
    chk({tag, " iter_cnt"}, 64'(iter), 64'(m_iter));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, " isConverge"}, 64'(conv), 64'd0);
    chk({tag, " timeout"}, 64'(tmo), 64'd0);
    chk({tag, " max_err"}, 64'(max_err), 64'd0);
    chk({tag, " iter_cnt"}, 64'(iter), 64'd0);
  endtask

  initial begin
    bit pass;
    longint mx;
    int bc, rc, d, neg;
    set_ident(1);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    go = 1'b1;
    repeat (2) @(negedge clk);
    run_check("identity");
    set_ident(-1);
    run_check("neg_identity");
    @(negedge clk) go = 1'b0;
    m_iter = 0;
    @(negedge clk) go = 1'b1;
    set_ident(1);
    wn[10] = 16'sh3F00;
    run_check("row2_off_1");
    chk("row2_off max256", 64'(max_err), 64'd256);
    run_check("row2_off_2");
    run_check("row2_off_3");
    set_ident(1);
    ref_model(pass, mx);
    m_iter++;
    bc = 0;
    rc = 0;
    @(negedge clk) en = 1'b1;
    repeat (40) begin
      @(negedge clk);
      bc += int'(busy);
      rc += int'(rd_en);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold busy_cycles", 64'(bc), 64'd18);
    chk("hold rd_pulses", 64'(rc), 64'd16);
    chk("hold iter_cnt", 64'(iter), 64'(m_iter));
    chk("hold isConverge", 64'(conv), 64'(pass));
    wn[5] = 16'sh3000;
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    repeat (7) @(negedge clk);
    go = 1'b0;
    #1;
    chk_zero("mid_reset");
    m_iter = 0;
    @(negedge clk) go = 1'b1;
    set_ident(1);
    run_check("after_reset");
    for (int k = 0; k < 12; k++) begin
      for (int r = 0; r < 4; r++) begin
        neg = $urandom_range(0, 1) ? -1 : 1;
        if ($urandom_range(0, 3) == 0) begin
          for (int c = 0; c < 4; c++) begin
            wn[r*4+c] = 16'($urandom);
            wo[r*4+c] = 16'($urandom);
          end
        end else begin
          for (int c = 0; c < 4; c++) begin
            d = (r == c) ? 16384 + int'($urandom_range(0, 40)) - 20 : int'($urandom_range(0, 4)) - 2;
            wn[r*4+c] = 16'(neg * d);
            wo[r*4+c] = 16'((r == c) ? 16384 : int'($urandom_range(0, 4)) - 2);
          end
        end
      end
      run_check($sformatf("rand%0d", k));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
